// File: rtl/hazard_mdu.sv
// rtl/hazard_mdu.sv - hazard unit for the 5-stage MIPS pipeline: forwarding, stalls, MDU interlock, stall counter
module hazard_mdu #(
    parameter int REGBITS = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNTW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REGBITS-1:0]  rsD,
    input  logic [REGBITS-1:0]  rtD,
    input  logic [REGBITS-1:0]  rsE,
    input  logic [REGBITS-1:0]  rtE,
    input  logic [REGBITS-1:0]  writeregE,
    input  logic [REGBITS-1:0]  writeregM,
    input  logic [REGBITS-1:0]  writeregW,
    input  logic                regwriteE,
    input  logic                regwriteM,
    input  logic                regwriteW,
    input  logic                memtoregE,
    input  logic                memtoregM,
    input  logic                branchD,
    input  logic                bneD,
    input  logic                mduopD,
    input  logic                divD,
    input  logic                mfhiloD,
    output logic                forwardaD,
    output logic                forwardbD,
    output logic [1:0]          forwardaE,
    output logic [1:0]          forwardbE,
    output logic                stallF,
    output logic                stallD,
    output logic                flushE,
    output logic                mdu_start,
    output logic                mdu_busy,
    output logic [CNTW-1:0]     stall_cycles
);
    localparam int CW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            lwstall, branchstall, mdustall;
    logic            hazE, hazM;

    always_comb begin
        forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
        forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

        forwardaE = 2'b00;
        if ((rsE != '0) && (rsE == writeregM) && regwriteM)      forwardaE = 2'b10;
        else if ((rsE != '0) && (rsE == writeregW) && regwriteW) forwardaE = 2'b01;

        forwardbE = 2'b00;
        if ((rtE != '0) && (rtE == writeregM) && regwriteM)      forwardbE = 2'b10;
        else if ((rtE != '0) && (rtE == writeregW) && regwriteW) forwardbE = 2'b01;
    end

    // Register 0 is never a real producer, so it can neither stall nor forward.
    assign lwstall     = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
    assign hazE        = regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
    assign hazM        = memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
    assign branchstall = (branchD || bneD) && (hazE || hazM);
    assign mdu_busy    = (state == BUSY);
    assign mdustall    = mdu_busy && (mduopD || mfhiloD);

    assign stallD    = lwstall || branchstall || mdustall;
    assign stallF    = stallD;
    assign flushE    = stallD;
    assign mdu_start = mduopD && !stallD;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (mdu_start) begin
                state_next = BUSY;
                cnt_next   = divD ? DIV_LOAD : MUL_LOAD;
            end
            BUSY: if (cnt == '0) state_next = IDLE;
                  else           cnt_next   = cnt - 1'b1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stallD && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_mdu.sv
// tb/tb_hazard_mdu.sv - self-checking bench for hazard_mdu against a behavioural model
module tb_hazard_mdu;
    logic       clk = 0, reset = 1;
    logic [4:0] rsD = 0, rtD = 0, rsE = 0, rtE = 0, writeregE = 0, writeregM = 0, writeregW = 0;
    logic       regwriteE = 0, regwriteM = 0, regwriteW = 0, memtoregE = 0, memtoregM = 0;
    logic       branchD = 0, bneD = 0, mduopD = 0, divD = 0, mfhiloD = 0;

    logic       fad, fbd, stf, std, fle, start, busy;
    logic [1:0] fae, fbe;
    logic [15:0] sc;
    logic       s_fad, s_fbd, s_stf, s_std, s_fle, s_start, s_busy;
    logic [1:0] s_fae, s_fbe;
    logic [2:0] s_sc;

    int n_cmp = 0, n_bad = 0;
    int busy_left = 0, m_sc = 0, m_sc3 = 0;
    bit started = 0;

    always #5 clk = ~clk;

    hazard_mdu u_dut (
        .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .bneD(bneD),
        .mduopD(mduopD), .divD(divD), .mfhiloD(mfhiloD),
        .forwardaD(fad), .forwardbD(fbd), .forwardaE(fae), .forwardbE(fbe),
        .stallF(stf), .stallD(std), .flushE(fle), .mdu_start(start), .mdu_busy(busy),
        .stall_cycles(sc));

    hazard_mdu #(.CNTW(3)) u_sat (
        .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .bneD(bneD),
        .mduopD(mduopD), .divD(divD), .mfhiloD(mfhiloD),
        .forwardaD(s_fad), .forwardbD(s_fbd), .forwardaE(s_fae), .forwardbE(s_fbe),
        .stallF(s_stf), .stallD(s_std), .flushE(s_fle), .mdu_start(s_start), .mdu_busy(s_busy),
        .stall_cycles(s_sc));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a source register matches a producer only if it is nonzero and being written.
    function automatic bit hits(input logic [4:0] src, input logic [4:0] dst, input logic we);
        return we && src != 0 && src == dst;
    endfunction

    function automatic int m_fwdE(input logic [4:0] src);
        if (hits(src, writeregM, regwriteM)) return 2;
        if (hits(src, writeregW, regwriteW)) return 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit lw, br, md;
        lw = memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD);
        br = (branchD || bneD) &&
             (hits(rsD, writeregE, regwriteE) || hits(rtD, writeregE, regwriteE) ||
              hits(rsD, writeregM, memtoregM) || hits(rtD, writeregM, memtoregM));
        md = (busy_left > 0) && (mduopD || mfhiloD);
        return lw || br || md;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy_left = 0; m_sc = 0; m_sc3 = 0; started = 1;
        end else begin
            bit st;
            st = m_stall();
            if (st) begin
                m_sc  = (m_sc  < 65535) ? m_sc + 1  : m_sc;
                m_sc3 = (m_sc3 < 7)     ? m_sc3 + 1 : m_sc3;
            end
            if (busy_left > 0)        busy_left = busy_left - 1;
            else if (mduopD && !st)   busy_left = divD ? 32 : 4;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit st;
            st = m_stall();
            chk("forwardaD", fad, hits(rsD, writeregM, regwriteM));
            chk("forwardbD", fbd, hits(rtD, writeregM, regwriteM));
            chk("forwardaE", fae, m_fwdE(rsE));
            chk("forwardbE", fbe, m_fwdE(rtE));
            chk("stallD", std, st);
            chk("stallF", stf, st);
            chk("flushE", fle, st);
            chk("mdu_start", start, mduopD && !st);
            chk("mdu_busy", busy, busy_left > 0);
            chk("stall_cycles", sc, m_sc);
            chk("sat_stallD", s_std, st);
            chk("sat_mdu_busy", s_busy, busy_left > 0);
            chk("sat_stall_cycles", s_sc, m_sc3);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
        branchD = 0; bneD = 0; mduopD = 0; divD = 0; mfhiloD = 0;
    endtask

    task automatic do_reset();
        reset = 1; step(2); reset = 0;
    endtask

    initial begin
        int cyc;
        do_reset();
        @(negedge clk);
        chk("reset_stall_cycles", sc, 0);
        chk("reset_busy", busy, 0);

        rsE = 5; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1;
        @(negedge clk); chk("lit_fwdE_M", fae, 2);
        regwriteM = 0;
        @(negedge clk); chk("lit_fwdE_W", fae, 1);
        regwriteM = 1; rsE = 0;
        @(negedge clk); chk("lit_fwdE_r0", fae, 0);
        step(1); clear();

        memtoregE = 1; rtE = 8; rsD = 8;
        @(negedge clk);
        chk("lit_lw_stallF", stf, 1);
        chk("lit_lw_flushE", fle, 1);
        chk("lit_lw_fwdaE", fae, 0);
        step(3);
        @(negedge clk); chk("lit_lw_count3", sc, 3);
        step(10);
        @(negedge clk);
        chk("lit_sat_7", s_sc, 7);
        chk("lit_nosat_13", sc, 13);
        rtE = 0;
        @(negedge clk); chk("lit_lw_r0_nostall", std, 0);
        step(1); clear();

        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        @(negedge clk); chk("lit_beq_E_stall", std, 1);
        step(1); clear();
        bneD = 1; rtD = 4; memtoregM = 1; writeregM = 4;
        @(negedge clk); chk("lit_bne_Mload_stall", std, 1);
        step(1); clear();
        branchD = 1; rsD = 6; writeregM = 6; regwriteM = 1;
        @(negedge clk);
        chk("lit_beq_fwdaD", fad, 1);
        chk("lit_beq_nostall", std, 0);
        step(1); clear();

        do_reset();
        mduopD = 1;
        @(negedge clk); chk("lit_mul_start", start, 1);
        step(1); mduopD = 0; mfhiloD = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_mul_busy", busy, 1);
            chk("lit_mul_stall", std, 1);
            step(1);
        end
        @(negedge clk);
        chk("lit_mul_idle", busy, 0);
        chk("lit_mul_release", std, 0);
        chk("lit_mul_count4", sc, 4);
        step(1); clear();

        do_reset();
        mduopD = 1; divD = 1;
        step(1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            step(1);
        end
        @(negedge clk);
        chk("lit_div_busy_cycles", cyc, 32);
        chk("lit_div_b2b_start", start, 1);
        step(1);
        mduopD = 0;
        step(9);
        reset = 1; step(1); reset = 0;
        mfhiloD = 1;
        @(negedge clk);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_count", sc, 0);
        chk("lit_rst_nostall", std, 0);
        step(2); clear(); step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
